// File: rtl/io_pad_bank_ice40_pkg.sv
// Shared types, SB_IO settings and width helpers for the iCE40 pad bank.
package io_pad_bank_ice40_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PARK = 1'b1
  } cfg_state_t;

  // Non-registered tristate output, non-registered input, no pull-up.
  localparam logic [5:0] SB_IO_PIN_TYPE = 6'b1010_01;
  localparam logic       SB_IO_PULLUP   = 1'b0;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_pad_bank_ice40_if.sv
// Pad-bank configuration write port: valid/ready handshake plus error pulse.
interface io_pad_bank_ice40_if
  import io_pad_bank_ice40_pkg::*;
#(
  parameter int NPINS   = 4,
  parameter int TXCOUNT = 2,
  parameter int RXCOUNT = 2
);
  localparam int MUXWIDTH = clog2_min1(TXCOUNT + RXCOUNT);
  localparam int PINW     = clog2_min1(NPINS);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [PINW-1:0]     cfg_pin;
  logic [MUXWIDTH-1:0] cfg_sel;
  logic                cfg_err;

  modport master (output cfg_valid, cfg_pin, cfg_sel, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_pin, cfg_sel, output cfg_ready, cfg_err);

endinterface

// File: rtl/io_pad_bank_ice40_input_filter.sv
// Per-pad 2-flop synchroniser with optional debounce (IO_PAD_BANK_DEBOUNCE_EN).
module io_pad_bank_ice40_input_filter #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  input  logic hold,
  output logic filt
);

  if (DEBOUNCE < 1) begin : g_bad_param
    $error("io_pad_bank_ice40_input_filter: DEBOUNCE must be > 0");
  end

  logic sync_p0;
  logic sync_p1;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pad_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef IO_PAD_BANK_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_p2;
  logic          filt_p2;

  // Stage p2: filtered value only follows after DEBOUNCE matching samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2  <= '0;
      filt_p2 <= 1'b0;
    end else if (hold) begin
      cnt_p2  <= '0;
      filt_p2 <= 1'b0;
    end else if (sync_p1 == filt_p2) begin
      cnt_p2 <= '0;
    end else if (cnt_p2 == CNT_LAST) begin
      cnt_p2  <= '0;
      filt_p2 <= sync_p1;
    end else begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end
  end

  assign filt = filt_p2;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign filt        = sync_p1;
`endif

endmodule

// File: rtl/io_pad_bank_ice40.sv
// Bank of muxable iCE40 IO pads with run-time function select and TX turnaround.
// Optional debounce on receive inputs: define IO_PAD_BANK_DEBOUNCE_EN.
module io_pad_bank_ice40
  import io_pad_bank_ice40_pkg::*;
#(
  parameter  int NPINS      = 4,
  parameter  int TXCOUNT    = 2,
  parameter  int RXCOUNT    = 2,
  parameter  int TURNAROUND = 1,
  parameter  int DEBOUNCE   = 8,
  localparam int MUXWIDTH   = clog2_min1(TXCOUNT + RXCOUNT),
  localparam int PINW       = clog2_min1(NPINS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  inout  wire  [NPINS-1:0]            pin,
  input  logic [NPINS*TXCOUNT-1:0]    func_transmit,
  output logic [NPINS*RXCOUNT-1:0]    func_receive,
  io_pad_bank_ice40_if.slave          cfg,
  output logic [NPINS*MUXWIDTH-1:0]   sel_q
);

  localparam int NFUNC = TXCOUNT + RXCOUNT;
  localparam logic [MUXWIDTH:0] NFUNC_W = (MUXWIDTH+1)'(NFUNC);
  localparam logic [MUXWIDTH:0] RXC_W   = (MUXWIDTH+1)'(RXCOUNT);
  localparam logic [PINW:0]     NPINS_W = (PINW+1)'(NPINS);
  localparam int TXV  = 1 << MUXWIDTH;
  localparam int CNTW = clog2_min1(TURNAROUND);
  localparam logic [CNTW-1:0] PARK_LAST = CNTW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  if (NPINS < 1 || TXCOUNT < 1 || RXCOUNT < 1 || TURNAROUND < 0) begin : g_bad_param
    $error("io_pad_bank_ice40: NPINS/TXCOUNT/RXCOUNT must be > 0 and TURNAROUND >= 0");
  end

  function automatic logic is_tx_sel(input logic [MUXWIDTH-1:0] s);
    return ({1'b0, s} >= RXC_W) && ({1'b0, s} < NFUNC_W);
  endfunction

  function automatic logic is_rx_sel(input logic [MUXWIDTH-1:0] s);
    return {1'b0, s} < RXC_W;
  endfunction

  cfg_state_t                     state;
  logic [NPINS-1:0][MUXWIDTH-1:0] sel_r;
  logic [NPINS-1:0]               oe_r;
  logic [PINW-1:0]                park_pin;
  logic [MUXWIDTH-1:0]            park_sel;
  logic [CNTW-1:0]                park_cnt;
  logic                           ready_r;
  logic                           err_r;
  logic [NPINS-1:0]               pad_in;
  logic [NPINS-1:0]               filt;
  logic                           pin_ok;
  logic                           sel_ok;

  assign pin_ok = {1'b0, cfg.cfg_pin} < NPINS_W;
  assign sel_ok = {1'b0, cfg.cfg_sel} < NFUNC_W;

  // A pad leaving a transmit function is parked (OE low) before its new function
  // takes effect, so two drivers never meet on the pin back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel_r    <= '0;
      oe_r     <= '0;
      park_pin <= '0;
      park_sel <= '0;
      park_cnt <= '0;
      ready_r  <= 1'b1;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            if (!pin_ok || !sel_ok) begin
              err_r <= 1'b1;
            end else if (cfg.cfg_sel == sel_r[cfg.cfg_pin]) begin
            end else if (TURNAROUND > 0 && is_tx_sel(sel_r[cfg.cfg_pin])) begin
              oe_r[cfg.cfg_pin] <= 1'b0;
              park_pin          <= cfg.cfg_pin;
              park_sel          <= cfg.cfg_sel;
              park_cnt          <= '0;
              ready_r           <= 1'b0;
              state             <= ST_PARK;
            end else begin
              sel_r[cfg.cfg_pin] <= cfg.cfg_sel;
              oe_r[cfg.cfg_pin]  <= is_tx_sel(cfg.cfg_sel);
            end
          end
        end
        ST_PARK: begin
          if (park_cnt == PARK_LAST) begin
            sel_r[park_pin] <= park_sel;
            oe_r[park_pin]  <= is_tx_sel(park_sel);
            ready_r         <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            park_cnt <= park_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = ready_r;
  assign cfg.cfg_err   = err_r;
  assign sel_q         = sel_r;

  for (genvar p = 0; p < NPINS; p++) begin : g_pad
    logic [TXV-1:0]      tx_vec;
    logic [MUXWIDTH-1:0] tx_idx;
    logic                tx_d;

    assign tx_vec = TXV'(func_transmit[p*TXCOUNT +: TXCOUNT]);
    assign tx_idx = sel_r[p] - RXC_W[MUXWIDTH-1:0];
    assign tx_d   = tx_vec[tx_idx];

`ifdef SYNTHESIS
    SB_IO #(
      .PIN_TYPE (SB_IO_PIN_TYPE),
      .PULLUP   (SB_IO_PULLUP)
    ) u_sb_io (
      .PACKAGE_PIN   (pin[p]),
      .OUTPUT_ENABLE (oe_r[p]),
      .D_OUT_0       (tx_d),
      .D_IN_0        (pad_in[p])
    );
`else
    // Behavioural equivalent of the SB_IO tristate for simulation and lint.
    assign pin[p]    = oe_r[p] ? tx_d : 1'bz;
    assign pad_in[p] = pin[p];
`endif

    io_pad_bank_ice40_input_filter #(
      .DEBOUNCE (DEBOUNCE)
    ) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_in (pad_in[p]),
      .hold   (!is_rx_sel(sel_r[p])),
      .filt   (filt[p])
    );

    for (genvar r = 0; r < RXCOUNT; r++) begin : g_rx
      assign func_receive[p*RXCOUNT + r] = filt[p] && (sel_r[p] == MUXWIDTH'(r));
    end
  end

endmodule

// File: tb/tb_io_pad_bank_ice40.sv
// Randomised bench for io_pad_bank_ice40 against a per-pad behavioural model.
module tb_io_pad_bank_ice40;
  import io_pad_bank_ice40_pkg::*;

  // Non-power-of-two counts so out-of-range pins and selects are encodable.
  localparam int NP = 3;
  localparam int TX = 3;
  localparam int RX = 2;
  localparam int TA = 2;
  localparam int DB = 4;
  localparam int NF = TX + RX;
  localparam int MW = clog2_min1(NF);
  localparam int PW = clog2_min1(NP);

  logic               clk = 1'b0;
  logic               rst_n;
  wire  [NP-1:0]      pin;
  logic [NP-1:0]      tb_drv;
  logic [NP-1:0]      tb_en;
  logic [NP*TX-1:0]   func_transmit;
  wire  [NP*RX-1:0]   func_receive;
  wire  [NP*MW-1:0]   sel_q;

  io_pad_bank_ice40_if #(.NPINS(NP), .TXCOUNT(TX), .RXCOUNT(RX)) cfg_if ();

  for (genvar i = 0; i < NP; i++) begin : g_drv
    assign pin[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  io_pad_bank_ice40 #(
    .NPINS      (NP),
    .TXCOUNT    (TX),
    .RXCOUNT    (RX),
    .TURNAROUND (TA),
    .DEBOUNCE   (DB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin           (pin),
    .func_transmit (func_transmit),
    .func_receive  (func_receive),
    .cfg           (cfg_if),
    .sel_q         (sel_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: function per pad, pending park, pin history two edges deep.
  int m_sel [NP];
  bit m_s1  [NP];
  bit m_s2  [NP];
  int m_park_pin;
  int m_park_left;
  int m_park_tgt;
  bit m_err;
`ifdef IO_PAD_BANK_DEBOUNCE_EN
  bit m_filt [NP];
  int m_run  [NP];
`endif

  function automatic bit m_drives(input int p);
    return (m_sel[p] >= RX) && (p != m_park_pin);
  endfunction

  function automatic bit m_rx_val(input int p);
`ifdef IO_PAD_BANK_DEBOUNCE_EN
    return m_filt[p];
`else
    return m_s2[p];
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_sel[p] = 0;
      m_s1[p]  = 1'b0;
      m_s2[p]  = 1'b0;
`ifdef IO_PAD_BANK_DEBOUNCE_EN
      m_filt[p] = 1'b0;
      m_run[p]  = 0;
`endif
    end
    m_park_pin  = -1;
    m_park_left = 0;
    m_park_tgt  = 0;
    m_err       = 1'b0;
  endtask

  task automatic model_step();
    bit pv [NP];
    int cp;
    int cs;
    for (int p = 0; p < NP; p++)
      pv[p] = m_drives(p) ? func_transmit[p*TX + m_sel[p] - RX] : tb_drv[p];
`ifdef IO_PAD_BANK_DEBOUNCE_EN
    // Count consecutive synchronised samples that disagree with the filtered value.
    for (int p = 0; p < NP; p++) begin
      if (m_sel[p] >= RX) begin
        m_run[p]  = 0;
        m_filt[p] = 1'b0;
      end else if (m_s2[p] == m_filt[p]) begin
        m_run[p] = 0;
      end else begin
        m_run[p]++;
        if (m_run[p] == DB) begin
          m_filt[p] = m_s2[p];
          m_run[p]  = 0;
        end
      end
    end
`endif
    for (int p = 0; p < NP; p++) begin
      m_s2[p] = m_s1[p];
      m_s1[p] = pv[p];
    end
    m_err = 1'b0;
    cp = int'(cfg_if.cfg_pin);
    cs = int'(cfg_if.cfg_sel);
    if (m_park_pin >= 0) begin
      m_park_left--;
      if (m_park_left == 0) begin
        m_sel[m_park_pin] = m_park_tgt;
        m_park_pin = -1;
      end
    end else if (cfg_if.cfg_valid) begin
      if (cp >= NP || cs >= NF)               m_err = 1'b1;
      else if (cs == m_sel[cp])               m_err = 1'b0;
      else if (TA > 0 && m_sel[cp] >= RX) begin
        m_park_pin  = cp;
        m_park_left = TA;
        m_park_tgt  = cs;
      end else                                m_sel[cp] = cs;
    end
  endtask

  task automatic update_tb_en();
    for (int p = 0; p < NP; p++) tb_en[p] = !m_drives(p);
  endtask

  task automatic check_all();
    logic [NP*MW-1:0] es;
    logic [NP*RX-1:0] er;
    logic [NP-1:0]    ep;
    for (int p = 0; p < NP; p++) begin
      es[p*MW +: MW] = MW'(m_sel[p]);
      for (int r = 0; r < RX; r++) er[p*RX + r] = (m_sel[p] == r) && m_rx_val(p);
      ep[p] = m_drives(p) ? func_transmit[p*TX + m_sel[p] - RX] : tb_drv[p];
    end
    chk_val("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_park_pin < 0));
    chk_val("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    chk_val("sel_q", 32'(sel_q), 32'(es));
    chk_val("func_receive", 32'(func_receive), 32'(er));
    chk_val("pin", 32'(pin), 32'(ep));
  endtask

  // Drive one config cycle, advance the model on the edge, check on the next negedge.
  task automatic do_cycle(input bit v, input int pn, input int sl, input bit rnd);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_pin   = PW'(pn);
    cfg_if.cfg_sel   = MW'(sl);
    if (rnd) begin
      func_transmit = (NP*TX)'($urandom());
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) tb_drv[p] = ~tb_drv[p];
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    update_tb_en();
    #1;
    check_all();
  endtask

  initial begin
    rst_n            = 1'b1;
    tb_drv           = '0;
    tb_en            = '1;
    func_transmit    = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_pin   = '0;
    cfg_if.cfg_sel   = '0;
    #1 rst_n = 1'b0;
    model_reset();
    update_tb_en();
    #1;
    check_all();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Receive path latency on pad 0.
    tb_drv[0] = 1'b1;
    repeat (3) do_cycle(1'b0, 0, 0, 1'b0);

    // Pad 1 to TX function 0, then TX->TX through the park window, then TX->RX.
    func_transmit = 9'b000_001_000;
    do_cycle(1'b1, 1, 2, 1'b0);
    func_transmit = 9'b000_010_000;
    do_cycle(1'b1, 1, 3, 1'b0);
    do_cycle(1'b1, 0, 4, 1'b0);
    repeat (TA) do_cycle(1'b0, 0, 0, 1'b0);
    do_cycle(1'b1, 1, 1, 1'b0);
    repeat (TA + 1) do_cycle(1'b0, 0, 0, 1'b0);

    // Rejected writes: pin out of range, select out of range.
    do_cycle(1'b1, 3, 0, 1'b0);
    do_cycle(1'b1, 0, 5, 1'b0);
    do_cycle(1'b1, 2, 7, 1'b0);
    do_cycle(1'b0, 0, 0, 1'b0);

    repeat (3000)
      do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), 1'b1);

    // Asynchronous reset while a pad is parked.
    repeat (TA + 1) do_cycle(1'b0, 0, 0, 1'b1);
    do_cycle(1'b1, 2, 3, 1'b0);
    do_cycle(1'b1, 2, 4, 1'b0);
    chk_val("parked_before_reset", 32'(cfg_if.cfg_ready), 32'(0));
    tb_drv = NP'($urandom());
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_val("reset_ready", 32'(cfg_if.cfg_ready), 32'(1));
    chk_val("reset_sel_q", 32'(sel_q), 32'(0));
    update_tb_en();
    #1;
    check_all();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (200)
      do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
